pipe_stage_fifo: RTL and testbench

Parametrised inter-stage pipeline buffer for the RV64 core. It replaces fixed single-register stage latches (fetch→decode, decode→execute, etc.) with a DEPTH-entry elastic buffer. It adds valid/ready handshake, whole-stage flush, explicit bubble signalling and a stall-cycle counter. Payload is an opaque packed stage struct of DATA_W bits.

---
 rtl/pipe_stage_fifo.sv | 114 +++++++++++
 tb/tb_pipe_stage_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// -----------------------------------------------------------------------------
// pipe_stage_fifo
// Elastic inter-stage buffer for the RV64 pipeline. It replaces a single-register
// stage latch with a DEPTH-entry circular buffer. The buffer has a valid/ready
// handshake on both sides, a whole-stage flush, explicit bubble signalling and
// a saturating counter of downstream stall cycles.
//
// Parameters
//   DATA_W : payload width (packed stage struct), >= 1
//   DEPTH  : number of entries, >= 1, any value (need not be a power of two)
//   CNT_W  : width of the saturating stall counter
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high; overrides flush and transfers
//   in_valid      in   upstream presents in_data
//   in_ready      out  buffer can accept this cycle (count < DEPTH)
//   in_data       in   payload from upstream
//   flush         in   drop all held entries and this cycle's input
//   out_valid     out  head entry available downstream
//   out_ready     in   downstream consumes the head this cycle
//   out_data      out  head payload, all-zero while out_valid=0
//   out_is_bubble out  !out_valid
//   count         out  number of held entries
//   stall_cycles  out  saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module pipe_stage_fifo #(
   parameter int DATA_W = 256,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 32,
   localparam int CNT_OUT_W = $clog2(DEPTH + 1),
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_is_bubble,
   output logic [CNT_OUT_W-1:0] count,
   output logic [CNT_W-1:0]     stall_cycles
);

   localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_OUT_W-1:0] FULL_CNT  = CNT_OUT_W'(DEPTH);
   localparam logic [CNT_W-1:0]     STALL_MAX = '1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic              enq;
   logic              deq;

   // Explicit wrap compare so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      next_ptr = (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // in_ready depends only on registered count: a full buffer cannot accept
   // and dequeue in the same cycle, which halves DEPTH=1 throughput.
   assign in_ready      = (count < FULL_CNT);
   assign out_valid     = (count != '0);
   assign out_is_bubble = ~out_valid;

   // A bubble must decode as an inert instruction, so gate stale data to zero.
   assign out_data = out_valid ? mem[head] : '0;

   assign enq = in_valid & in_ready & ~flush;
   assign deq = out_valid & out_ready & ~flush;

   // Payload storage needs no reset: it is only visible through the count gate.
   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         mem[tail] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            tail <= next_ptr(tail);
         end
         if (deq) begin
            head <= next_ptr(head);
         end
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (out_valid && !out_ready && !flush && (stall_cycles != STALL_MAX)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Three buffers (DEPTH 2, 3, 1) share one input stream. A queue-based model
// per instance predicts every output after each clock edge.
module tb_pipe_stage_fifo;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          flush;
   logic          out_ready;

   logic          in_ready0, in_ready1, in_ready2;
   logic          out_valid0, out_valid1, out_valid2;
   logic          bub0, bub1, bub2;
   logic [DW-1:0] out_data0, out_data1, out_data2;
   logic [1:0]    count0, count1;
   logic [0:0]    count2;
   logic [31:0]   stall0;
   logic [7:0]    stall1;
   logic [3:0]    stall2;

   always #5 clk = ~clk;

   pipe_stage_fifo #(.DATA_W(DW), .DEPTH(2), .CNT_W(32)) u_d2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .flush(flush), .out_valid(out_valid0),
      .out_ready(out_ready), .out_data(out_data0), .out_is_bubble(bub0),
      .count(count0), .stall_cycles(stall0));

   pipe_stage_fifo #(.DATA_W(DW), .DEPTH(3), .CNT_W(8)) u_d3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .flush(flush), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1), .out_is_bubble(bub1),
      .count(count1), .stall_cycles(stall1));

   pipe_stage_fifo #(.DATA_W(DW), .DEPTH(1), .CNT_W(4)) u_d1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .flush(flush), .out_valid(out_valid2),
      .out_ready(out_ready), .out_data(out_data2), .out_is_bubble(bub2),
      .count(count2), .stall_cycles(stall2));

   int     n_cmp = 0;
   int     n_bad = 0;
   bit     model_ok = 1'b0;

   int     depth_of [3] = '{2, 3, 1};
   longint smax     [3] = '{64'hFFFF_FFFF, 64'd255, 64'd15};
   logic [DW-1:0] q [3][$];
   longint st [3];

   task automatic cmp(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      for (int d = 0; d < 3; d++) begin
         if (reset) begin
            q[d].delete();
            st[d] = 0;
         end else if (flush) begin
            q[d].delete();
         end else begin
            bit ov, ir;
            ov = (q[d].size() != 0);
            ir = (q[d].size() < depth_of[d]);
            if (ov && !out_ready && st[d] < smax[d]) st[d]++;
            if (ov && out_ready) void'(q[d].pop_front());
            if (in_valid && ir) q[d].push_back(in_data);
         end
      end
      if (reset) model_ok = 1'b1;
   endtask

   task automatic compare_all();
      longint a_v, a_b, a_d, a_c, a_r, a_s, e_d;
      for (int d = 0; d < 3; d++) begin
         case (d)
            0: begin a_v = out_valid0; a_b = bub0; a_d = out_data0; a_c = count0; a_r = in_ready0; a_s = stall0; end
            1: begin a_v = out_valid1; a_b = bub1; a_d = out_data1; a_c = count1; a_r = in_ready1; a_s = stall1; end
            default: begin a_v = out_valid2; a_b = bub2; a_d = out_data2; a_c = count2; a_r = in_ready2; a_s = stall2; end
         endcase
         e_d = (q[d].size() != 0) ? longint'(q[d][0]) : 0;
         cmp($sformatf("d%0d out_valid", depth_of[d]), a_v, longint'(q[d].size() != 0));
         cmp($sformatf("d%0d out_is_bubble", depth_of[d]), a_b, longint'(q[d].size() == 0));
         cmp($sformatf("d%0d out_data", depth_of[d]), a_d, e_d);
         cmp($sformatf("d%0d count", depth_of[d]), a_c, longint'(q[d].size()));
         cmp($sformatf("d%0d in_ready", depth_of[d]), a_r, longint'(q[d].size() < depth_of[d]));
         cmp($sformatf("d%0d stall_cycles", depth_of[d]), a_s, st[d]);
      end
   endtask

   // Drive before the edge, update the model on the edge, check half a cycle later.
   task automatic step(input logic rst, input logic fl, input logic iv,
                       input logic [DW-1:0] dat, input logic ordy);
      reset = rst; flush = fl; in_valid = iv; in_data = dat; out_ready = ordy;
      @(posedge clk);
      model_update();
      @(negedge clk);
      if (model_ok) compare_all();
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // Reset and idle
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      step(0, 0, 0, 16'h0, 0);
      cmp("lit idle out_valid", out_valid0, 0);
      cmp("lit idle bubble", bub1, 1);
      cmp("lit idle out_data", out_data0, 0);
      cmp("lit idle count", count1, 0);
      cmp("lit idle in_ready", in_ready2, 1);
      cmp("lit idle stall", stall0, 0);

      // Streaming through DEPTH=2
      step(0, 0, 1, 16'h11, 1);
      cmp("lit stream 1", out_data0, 16'h11);
      step(0, 0, 1, 16'h22, 1);
      cmp("lit stream 2", out_data0, 16'h22);
      step(0, 0, 1, 16'h33, 1);
      cmp("lit stream 3", out_data0, 16'h33);
      cmp("lit stream count", count0, 1);
      cmp("lit stream in_ready", in_ready0, 1);
      step(0, 0, 0, 16'h0, 1);

      // Fill and backpressure on DEPTH=3
      step(1, 0, 0, 16'h0, 0);
      step(0, 0, 1, 16'hA, 0);
      step(0, 0, 1, 16'hB, 0);
      step(0, 0, 1, 16'hC, 0);
      step(0, 0, 1, 16'hD, 0);
      step(0, 0, 1, 16'hD, 0);
      cmp("lit fill count", count1, 3);
      cmp("lit fill in_ready", in_ready1, 0);
      cmp("lit fill stall", stall1, 4);
      cmp("lit fill head", out_data1, 16'hA);
      step(0, 0, 1, 16'hD, 1);
      cmp("lit drain B", out_data1, 16'hB);
      step(0, 0, 1, 16'hD, 1);
      cmp("lit drain C", out_data1, 16'hC);
      step(0, 0, 0, 16'h0, 1);
      cmp("lit drain D", out_data1, 16'hD);
      step(0, 0, 0, 16'h0, 1);
      cmp("lit drain empty", out_valid1, 0);

      // Flush with two entries held and a valid input
      step(0, 0, 1, 16'h66, 0);
      step(0, 0, 1, 16'h77, 0);
      step(0, 1, 1, 16'h55, 0);
      cmp("lit flush count", count1, 0);
      cmp("lit flush valid", out_valid1, 0);
      cmp("lit flush data", out_data1, 0);
      step(0, 0, 0, 16'h0, 1);
      cmp("lit flush stays empty", out_valid1, 0);

      // Simultaneous enqueue/dequeue at count=1 on DEPTH=2
      step(0, 0, 1, 16'h31, 0);
      step(0, 0, 1, 16'h32, 1);
      cmp("lit simul count", count0, 1);
      cmp("lit simul data", out_data0, 16'h32);
      step(0, 0, 0, 16'h0, 1);

      // DEPTH=1: alternating throughput, then stall saturation at 15
      step(1, 0, 0, 16'h0, 0);
      step(0, 0, 1, 16'h41, 1);
      cmp("lit d1 alt 1", out_valid2, 1);
      step(0, 0, 1, 16'h42, 1);
      cmp("lit d1 alt 0", out_valid2, 0);
      step(0, 0, 1, 16'h43, 1);
      cmp("lit d1 alt 1b", out_valid2, 1);
      cmp("lit d1 alt data", out_data2, 16'h43);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0, 0);
      cmp("lit d1 stall 10", stall2, 10);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0, 0);
      cmp("lit d1 stall sat", stall2, 15);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic r, f, v, o;
         int   bias;
         bias = (i / 500) % 3;
         r = ($urandom_range(0, 199) == 0);
         f = ($urandom_range(0, 39) == 0);
         v = ($urandom_range(0, 9) < 7);
         o = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5)));
         step(r, f, v, DW'($urandom), o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
